fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a fetch PC driving instruction memory and a 2-entry registered fetch buffer.
// Optional macro FETCH_PERF_EN adds perf_fetches / perf_stalls counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stalls
`endif
);

  localparam int unsigned DEPTH = 2;
  localparam logic [1:0]  FULL  = 2'(DEPTH);

  logic [31:0] fetch_pc;
  logic [31:0] buf_instr [DEPTH];
  logic [31:0] buf_pc    [DEPTH];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        pop;
  logic        fetch;
  logic [1:0]  redirect_lsb_unused;

  assign redirect_lsb_unused = redirect_pc[1:0];

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;

  // Fullness is judged before the pop, so a full buffer never refills in the same cycle.
  assign pop   = out_valid & out_ready;
  assign fetch = (count != FULL) & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      if (fetch) begin
        buf_instr[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]    <= fetch_pc;
        wr_ptr            <= ~wr_ptr;
        fetch_pc          <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({fetch, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetches <= '0;
      perf_stalls  <= '0;
    end else begin
      if (fetch) begin
        perf_fetches <= perf_fetches + 32'd1;
      end
      if ((count == FULL) && !pop) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences and a randomized run
// checked against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_stalls;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetches(perf_fetches),
    .perf_stalls(perf_stalls)
`endif
  );

  // Reference model: pcs held in the buffer, the next fetch address and the perf totals.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetches;
  logic [31:0] m_stalls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst_n          = rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic model_check();
    logic        v;
    logic [31:0] hp;
    v  = (m_q.size() != 0);
    hp = v ? m_q[0] : 32'h0;
    check("model_valid", {31'b0, out_valid}, {31'b0, v});
    check("model_pc", out_pc, hp);
    check("model_instr", out_instr, v ? (hp ^ KEY) : 32'h0);
    check("model_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_EN
    check("model_perf_fetches", perf_fetches, m_fetches);
    check("model_perf_stalls", perf_stalls, m_stalls);
`endif
  endtask

  task automatic tick();
    bit do_pop, do_fetch;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_pc      = 32'h0;
      m_fetches = 32'h0;
      m_stalls  = 32'h0;
    end else begin
      do_pop   = (m_q.size() != 0) && out_ready;
      do_fetch = (m_q.size() < 2) && !redirect_valid;
      if (do_fetch) m_fetches = m_fetches + 1;
      if (m_q.size() == 2 && !do_pop) m_stalls = m_stalls + 1;
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (do_pop) void'(m_q.pop_front());
        if (do_fetch) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    drive(rst, rdy, rv, rpc);
    model_check();
    tick();
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[28];

  initial begin
    // Streaming
    vecs[0]  = '{1, 1, 0, 32'h0, 0, 32'h0, 32'h0};
    vecs[1]  = '{1, 1, 0, 32'h0, 1, 32'h0, 32'h4};
    vecs[2]  = '{1, 1, 0, 32'h0, 1, 32'h4, 32'h8};
    vecs[3]  = '{1, 1, 0, 32'h0, 1, 32'h8, 32'hC};
    // Reset, then 5 cycles of backpressure and drain
    vecs[4]  = '{0, 0, 0, 32'h0, 1, 32'hC, 32'h10};
    vecs[5]  = '{1, 0, 0, 32'h0, 0, 32'h0, 32'h0};
    vecs[6]  = '{1, 0, 0, 32'h0, 1, 32'h0, 32'h4};
    vecs[7]  = '{1, 0, 0, 32'h0, 1, 32'h0, 32'h8};
    vecs[8]  = '{1, 0, 0, 32'h0, 1, 32'h0, 32'h8};
    vecs[9]  = '{1, 0, 0, 32'h0, 1, 32'h0, 32'h8};
    vecs[10] = '{1, 1, 0, 32'h0, 1, 32'h0, 32'h8};
    vecs[11] = '{1, 1, 0, 32'h0, 1, 32'h4, 32'h8};
    vecs[12] = '{1, 1, 0, 32'h0, 1, 32'h8, 32'hC};
    // Flush from full
    vecs[13] = '{1, 0, 0, 32'h0, 1, 32'hC, 32'h10};
    vecs[14] = '{1, 0, 1, 32'h40, 1, 32'hC, 32'h14};
    vecs[15] = '{1, 0, 0, 32'h0, 0, 32'h0, 32'h40};
    vecs[16] = '{1, 1, 0, 32'h0, 1, 32'h40, 32'h44};
    // Misaligned redirect, back-to-back redirect, address wrap
    vecs[17] = '{1, 1, 1, 32'h43, 1, 32'h44, 32'h48};
    vecs[18] = '{1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h40};
    vecs[19] = '{1, 1, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFFC};
    vecs[20] = '{1, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0};
    vecs[21] = '{1, 1, 0, 32'h0, 1, 32'h0, 32'h4};
    // Reset while full, then resume
    vecs[22] = '{1, 0, 0, 32'h0, 1, 32'h4, 32'h8};
    vecs[23] = '{1, 0, 0, 32'h0, 1, 32'h4, 32'hC};
    vecs[24] = '{0, 0, 0, 32'h0, 1, 32'h4, 32'hC};
    vecs[25] = '{1, 1, 0, 32'h0, 0, 32'h0, 32'h0};
    vecs[26] = '{1, 1, 0, 32'h0, 1, 32'h0, 32'h4};
    vecs[27] = '{1, 1, 0, 32'h0, 1, 32'h4, 32'h8};

    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_pc = '0; m_fetches = '0; m_stalls = '0;

    // Reset takes precedence over a concurrent redirect
    drive(0, 1, 1, 32'h80);
    tick();
    drive(0, 1, 0, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    check("reset_instr", out_instr, 32'h0);
    check("reset_pc", out_pc, 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    model_check();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
      check($sformatf("vec%0d_instr", i), out_instr,
            vecs[i].e_valid ? (vecs[i].e_pc ^ KEY) : 32'h0);
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      model_check();
      tick();
    end

    // Handshake coinciding with a redirect: entry consumed, buffer still flushed
    step(1, 0, 0, 32'h0);
    step(1, 1, 1, 32'h100);
    drive(1, 1, 0, 32'h0);
    check("hs_redirect_valid", {31'b0, out_valid}, 32'h0);
    check("hs_redirect_addr", imem_addr, 32'h100);
    model_check();
    tick();
    drive(1, 1, 0, 32'h0);
    check("hs_redirect_pc", out_pc, 32'h100);
    model_check();
    tick();

    // Randomized run against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic        r, rdy, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(63) != 0);
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(7) == 0);
      rpc = $urandom();
      step(r, rdy, rv, rpc);
    end

`ifdef FETCH_PERF_EN
    step(0, 0, 0, 32'h0);
    for (int n = 0; n < 10; n++) step(1, 1, 0, 32'h0);
    for (int n = 0; n < 4; n++) step(1, 0, 0, 32'h0);
    drive(1, 0, 0, 32'h0);
    check("perf_fetches_11", perf_fetches, 32'd11);
    check("perf_stalls_3", perf_stalls, 32'd3);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
